// File: rtl/vc_allocator_rr_pkg.sv
// vc_allocator_rr_pkg: NoC sizing, index types and class helpers shared by the VC allocator.
package vc_allocator_rr_pkg;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM = 4;
  localparam int CLASS_NUM = 2;
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int CLASS_SIZE = CLASS_NUM > 2 ? $clog2(CLASS_NUM) : 1;
  localparam int VPC = VC_NUM / CLASS_NUM;
  typedef logic [PORT_SIZE-1:0] port_t;
  typedef logic [VC_SIZE-1:0] vc_t;
  typedef logic [CLASS_SIZE-1:0] class_t;
  function automatic vc_t class_next(vc_t k, class_t c);
    return (int'(k) + 1 == (int'(c) + 1) * VPC) ? vc_t'(int'(c) * VPC) : vc_t'(int'(k) + 1);
  endfunction
endpackage

// File: rtl/vc_allocator_rr_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, one-hot grant, search begins at ptr and wraps.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);
  always_comb begin
    int idx;
    logic found;
    grant = '0;
    idx = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vc_allocator_rr.sv
// vc_allocator_rr: class-partitioned two-stage input-first round-robin VC allocator
// with downstream VC occupancy tracking.
module vc_allocator_rr
  import vc_allocator_rr_pkg::*;
#(
  parameter int RR_VC_SELECT = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic   [PORT_NUM-1:0][VC_NUM-1:0]   vc_request_i,
  input  port_t  [PORT_NUM-1:0][VC_NUM-1:0]   out_port_i,
  input  class_t [PORT_NUM-1:0][VC_NUM-1:0]   class_i,
  input  logic   [PORT_NUM-1:0][VC_NUM-1:0]   idle_downstream_vc_i,
  output logic   [PORT_NUM-1:0][VC_NUM-1:0]   vc_valid_o,
  output vc_t    [PORT_NUM-1:0][VC_NUM-1:0]   vc_new_o
);
  if (VC_NUM % CLASS_NUM != 0) begin : g_bad_class
    $fatal(1, "VC_NUM must be a multiple of CLASS_NUM");
  end

  logic   [PORT_NUM-1:0][VC_NUM-1:0]    avail, eligible, in_gnt, clr;
  logic   [PORT_NUM-1:0][CLASS_NUM-1:0] class_avail;
  logic   [PORT_NUM-1:0][PORT_NUM-1:0]  out_req, out_gnt;
  logic   [PORT_NUM-1:0]                in_any, won, out_any;
  vc_t    [PORT_NUM-1:0]                in_ptr, in_v, sel;
  port_t  [PORT_NUM-1:0]                out_ptr, in_port, out_w;
  class_t [PORT_NUM-1:0]                in_cls, out_c;
  vc_t    [PORT_NUM-1:0][CLASS_NUM-1:0] vc_ptr;

  always_comb begin
    class_avail = '0;
    for (int d = 0; d < PORT_NUM; d++)
      for (int c = 0; c < CLASS_NUM; c++)
        class_avail[d][c] = |avail[d][c*VPC +: VPC];
  end

  // Out-of-range port or class never becomes eligible, so it can never win either stage.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        eligible[p][v] = vc_request_i[p][v] && int'(out_port_i[p][v]) < PORT_NUM &&
                         int'(class_i[p][v]) < CLASS_NUM && class_avail[out_port_i[p][v]][class_i[p][v]];
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
    rr_arbiter #(.N(VC_NUM)) u_arb (
      .request(eligible[p]),
      .ptr    (in_ptr[p]),
      .grant  (in_gnt[p])
    );
  end

  always_comb begin
    in_any = '0;
    in_v = '0;
    in_port = '0;
    in_cls = '0;
    out_req = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      in_any[p] = |in_gnt[p];
      for (int v = 0; v < VC_NUM; v++)
        if (in_gnt[p][v]) in_v[p] = vc_t'(v);
      in_port[p] = out_port_i[p][in_v[p]];
      in_cls[p] = class_i[p][in_v[p]];
      for (int d = 0; d < PORT_NUM; d++)
        out_req[d][p] = in_any[p] && int'(in_port[p]) == d;
    end
  end

  for (genvar d = 0; d < PORT_NUM; d++) begin : g_out
    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .request(out_req[d]),
      .ptr    (out_ptr[d]),
      .grant  (out_gnt[d])
    );
  end

  // A pointer still outside its class range (e.g. after reset) starts the search at the class base.
  always_comb begin
    int base, start, k;
    logic found;
    out_any = '0;
    out_w = '0;
    out_c = '0;
    sel = '0;
    base = 0;
    start = 0;
    k = 0;
    found = 1'b0;
    for (int d = 0; d < PORT_NUM; d++) begin
      out_any[d] = |out_gnt[d];
      for (int p = 0; p < PORT_NUM; p++)
        if (out_gnt[d][p]) out_w[d] = port_t'(p);
      out_c[d] = in_cls[out_w[d]];
      base = int'(out_c[d]) * VPC;
      start = (RR_VC_SELECT != 0 && int'(vc_ptr[d][out_c[d]]) >= base &&
               int'(vc_ptr[d][out_c[d]]) < base + VPC) ? int'(vc_ptr[d][out_c[d]]) - base : 0;
      found = 1'b0;
      for (int i = 0; i < VPC; i++) begin
        k = base + (start + i) % VPC;
        if (!found && avail[d][k]) begin
          sel[d] = vc_t'(k);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    won = '0;
    clr = '0;
    vc_valid_o = '0;
    vc_new_o = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int d = 0; d < PORT_NUM; d++)
        won[p] = won[p] | out_gnt[d][p];
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) begin
        vc_valid_o[p][v] = in_gnt[p][v] && won[p] && !rst;
        vc_new_o[p][v] = vc_valid_o[p][v] ? sel[in_port[p]] : '0;
      end
    for (int d = 0; d < PORT_NUM; d++)
      for (int k = 0; k < VC_NUM; k++)
        clr[d][k] = out_any[d] && int'(sel[d]) == k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail <= '1;
      in_ptr <= '0;
      out_ptr <= '0;
      vc_ptr <= '0;
    end else begin
      avail <= (avail | idle_downstream_vc_i) & ~clr;
      for (int p = 0; p < PORT_NUM; p++)
        if (won[p]) in_ptr[p] <= vc_t'((int'(in_v[p]) + 1) % VC_NUM);
      for (int d = 0; d < PORT_NUM; d++)
        if (out_any[d]) begin
          out_ptr[d] <= port_t'((int'(out_w[d]) + 1) % PORT_NUM);
          vc_ptr[d][out_c[d]] <= class_next(sel[d], out_c[d]);
        end
    end
  end

  a_grant_free: assert property (@(posedge clk) disable iff (rst) (clr & ~avail) == '0);
  a_no_grant_release: assert property (@(posedge clk) disable iff (rst)
    (clr & idle_downstream_vc_i & ~avail) == '0);
endmodule

// File: tb/tb_vc_allocator_rr.sv
// tb_vc_allocator_rr: randomized and directed checks of both VC selection modes against a
// behavioural allocation model.
module tb_vc_allocator_rr;
  import vc_allocator_rr_pkg::*;
  localparam int P = PORT_NUM, V = VC_NUM, C = CLASS_NUM;

  logic clk = 1'b0, rst = 1'b1;
  logic   [P-1:0][V-1:0] req, idle, valid_rr, valid_lf, want;
  port_t  [P-1:0][V-1:0] port;
  class_t [P-1:0][V-1:0] cls;
  vc_t    [P-1:0][V-1:0] new_rr, new_lf;
  logic   [P-1:0][V-1:0] exp_valid [2];
  vc_t    [P-1:0][V-1:0] exp_new [2];
  int m_avail [2][P][V];
  int m_in [2][P];
  int m_out [2][P];
  int m_vc [2][P][C];
  int g_p [2][P], g_v [2][P], g_c [2][P], g_k [2][P];
  int tests = 0, failed = 0;

  always #5 clk = ~clk;

  vc_allocator_rr #(.RR_VC_SELECT(1)) u_rr (
    .clk(clk), .rst(rst), .vc_request_i(req), .out_port_i(port), .class_i(cls),
    .idle_downstream_vc_i(idle), .vc_valid_o(valid_rr), .vc_new_o(new_rr));
  vc_allocator_rr #(.RR_VC_SELECT(0)) u_lf (
    .clk(clk), .rst(rst), .vc_request_i(req), .out_port_i(port), .class_i(cls),
    .idle_downstream_vc_i(idle), .vc_valid_o(valid_lf), .vc_new_o(new_lf));

  // Model index 1 is round-robin VC selection, index 0 lowest-free.
  function automatic bit eligible(int m, int p, int v);
    int d = int'(port[p][v]);
    int c = int'(cls[p][v]);
    bit any = 1'b0;
    if (!req[p][v] || d >= P || c >= C) return 1'b0;
    for (int k = 0; k < V; k++) if (k / VPC == c && m_avail[m][d][k] != 0) any = 1'b1;
    return any;
  endfunction

  function automatic int pick(int m, int d, int c);
    int best = -1, first = -1;
    for (int k = 0; k < V; k++)
      if (k / VPC == c && m_avail[m][d][k] != 0) begin
        if (first < 0) first = k;
        if (m == 1 && best < 0 && k >= m_vc[m][d][c]) best = k;
      end
    return best >= 0 ? best : first;
  endfunction

  task automatic reset_model();
    for (int m = 0; m < 2; m++)
      for (int d = 0; d < P; d++) begin
        m_in[m][d] = 0;
        m_out[m][d] = 0;
        for (int c = 0; c < C; c++) m_vc[m][d][c] = 0;
        for (int k = 0; k < V; k++) m_avail[m][d][k] = 1;
      end
  endtask

  task automatic eval_model();
    for (int m = 0; m < 2; m++) begin
      int win [P];
      exp_valid[m] = '0;
      exp_new[m] = '0;
      for (int p = 0; p < P; p++) begin
        win[p] = -1;
        for (int i = 0; i < V; i++)
          if (win[p] < 0 && eligible(m, p, (m_in[m][p] + i) % V)) win[p] = (m_in[m][p] + i) % V;
      end
      for (int d = 0; d < P; d++) begin
        g_p[m][d] = -1;
        for (int i = 0; i < P; i++) begin
          int p = (m_out[m][d] + i) % P;
          if (g_p[m][d] < 0 && win[p] >= 0 && int'(port[p][win[p]]) == d) begin
            g_p[m][d] = p;
            g_v[m][d] = win[p];
            g_c[m][d] = int'(cls[p][win[p]]);
            g_k[m][d] = pick(m, d, g_c[m][d]);
            exp_valid[m][p][win[p]] = 1'b1;
            exp_new[m][p][win[p]] = vc_t'(g_k[m][d]);
          end
        end
      end
    end
  endtask

  task automatic commit_model();
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < P; d++)
        for (int k = 0; k < V; k++)
          if (idle[d][k] && m_avail[m][d][k] == 0) m_avail[m][d][k] = 1;
      for (int d = 0; d < P; d++)
        if (g_p[m][d] >= 0) begin
          m_avail[m][d][g_k[m][d]] = 0;
          m_in[m][g_p[m][d]] = (g_v[m][d] + 1) % V;
          m_out[m][d] = (g_p[m][d] + 1) % P;
          m_vc[m][d][g_c[m][d]] = (g_k[m][d] + 1 == (g_c[m][d] + 1) * VPC) ? g_c[m][d] * VPC : g_k[m][d] + 1;
        end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    commit_model();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0;
    idle = '0;
    port = '0;
    cls = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req[0][0] = 1'b1; port[0][0] = 3'd1; cls[0][0] = 1'b0;
    req[0][1] = 1'b1; port[0][1] = 3'd1; cls[0][1] = 1'b1;
    repeat (2) begin
      #1 eval_model();
      tests++;
      if ({valid_rr, new_rr, valid_lf, new_lf} !== {exp_valid[1], exp_new[1], exp_valid[0], exp_new[0]}) begin
        failed++;
        $display("FAIL reset_fill: rr %h/%h lf %h/%h expected rr %h/%h lf %h/%h", valid_rr, new_rr, valid_lf, new_lf, exp_valid[1], exp_new[1], exp_valid[0], exp_new[0]);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    tests++;
    if (valid_rr !== '0 || valid_lf !== '0 || new_rr !== '0 || new_lf !== '0) begin
      failed++;
      $display("FAIL reset_outputs: rr %h/%h lf %h/%h expected all 0", valid_rr, new_rr, valid_lf, new_lf);
    end
    repeat (2) @(negedge clk);
    reset_model();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 eval_model();
      tests++;
      if (valid_rr[0] == '0 || valid_lf[0] == '0 ||
          {valid_rr, new_rr, valid_lf, new_lf} !== {exp_valid[1], exp_new[1], exp_valid[0], exp_new[0]}) begin
        failed++;
        $display("FAIL reset_regrant%0d: rr %h/%h lf %h/%h expected rr %h/%h lf %h/%h", i, valid_rr, new_rr, valid_lf, new_lf, exp_valid[1], exp_new[1], exp_valid[0], exp_new[0]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_single();
    int exp_k [6] = '{2, 3, -1, -1, -1, 2};
    do_reset();
    req[0][1] = 1'b1; port[0][1] = 3'd2; cls[0][1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle[2][2] = (i == 4);
      #1 eval_model();
      want = '0;
      if (exp_k[i] >= 0) want[0][1] = 1'b1;
      tests++;
      if (valid_rr !== want || valid_lf !== want || (exp_k[i] >= 0 && (int'(new_rr[0][1]) != exp_k[i] || int'(new_lf[0][1]) != exp_k[i]))) begin
        failed++;
        $display("FAIL single_cycle%0d: valid rr %h lf %h new rr %0d lf %0d expected valid %h new %0d", i, valid_rr, valid_lf, new_rr[0][1], new_lf[0][1], want, exp_k[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    int exp_w [6] = '{0, 1, -1, -1, -1, 3};
    logic [P-1:0] got = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < P; p++) begin
        req[p][0] = (p == 0 || p == 1 || p == 3) && !got[p];
        port[p][0] = 3'd4;
      end
      idle[4][0] = (i == 4);
      #1 eval_model();
      want = '0;
      if (exp_w[i] >= 0) want[exp_w[i]][0] = 1'b1;
      tests++;
      if (valid_rr !== want || valid_lf !== want ||
          {new_rr, new_lf} !== {exp_new[1], exp_new[0]}) begin
        failed++;
        $display("FAIL contention_cycle%0d: valid rr %h lf %h new rr %h lf %h expected valid %h new %h/%h", i, valid_rr, valid_lf, new_rr, new_lf, want, exp_new[1], exp_new[0]);
      end
      for (int p = 0; p < P; p++) got[p] = exp_valid[1][p][0];
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_input_rr();
    logic [V-1:0] done = '0;
    do_reset();
    for (int i = 0; i < V; i++) begin
      for (int v = 0; v < V; v++) begin
        req[1][v] = !done[v];
        port[1][v] = port_t'(v);
      end
      #1 eval_model();
      want = '0;
      want[1][i] = 1'b1;
      tests++;
      if (valid_rr !== want || valid_lf !== want || new_rr !== exp_new[1]) begin
        failed++;
        $display("FAIL input_rr_cycle%0d: valid rr %h lf %h new %h expected valid %h new %h", i, valid_rr, valid_lf, new_rr, want, exp_new[1]);
      end
      done = done | exp_valid[1][1];
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_vc_select();
    do_reset();
    req[0][0] = 1'b1; port[0][0] = 3'd3;
    #1 eval_model();
    tests++;
    if (valid_rr[0][0] !== 1'b1 || new_rr[0][0] !== 2'd0 || valid_lf[0][0] !== 1'b1 || new_lf[0][0] !== 2'd0) begin
      failed++;
      $display("FAIL vc_select_first: rr %b/%0d lf %b/%0d expected 1/0 1/0", valid_rr[0][0], new_rr[0][0], valid_lf[0][0], new_lf[0][0]);
    end
    tick();
    req = '0;
    idle[3][0] = 1'b1;
    #1 eval_model();
    tick();
    idle = '0;
    req[0][0] = 1'b1;
    #1 eval_model();
    tests++;
    if (valid_rr[0][0] !== 1'b1 || new_rr[0][0] !== 2'd1 || valid_lf[0][0] !== 1'b1 || new_lf[0][0] !== 2'd0) begin
      failed++;
      $display("FAIL vc_select_second: rr %b/%0d lf %b/%0d expected 1/1 1/0", valid_rr[0][0], new_rr[0][0], valid_lf[0][0], new_lf[0][0]);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_boundaries();
    do_reset();
    req[0][0] = 1'b1; port[0][0] = 3'd5;
    req[1][1] = 1'b1; port[1][1] = 3'd7; cls[1][1] = 1'b1;
    req[2][2] = 1'b1; port[2][2] = 3'd6;
    req[2][3] = 1'b1; port[2][3] = 3'd1;
    for (int i = 0; i < 3; i++) begin
      #1 eval_model();
      want = '0;
      if (i == 0) want[2][3] = 1'b1;
      tests++;
      if (valid_rr !== want || valid_lf !== want) begin
        failed++;
        $display("FAIL bad_port_cycle%0d: valid rr %h lf %h expected %h", i, valid_rr, valid_lf, want);
      end
      req[2][3] = 1'b0;
      tick();
    end
    clear_inputs();
    do_reset();
    idle = '1;
    #1 eval_model();
    tick();
    idle = '0;
    req[2][0] = 1'b1; port[2][0] = 3'd1;
    #1 eval_model();
    tests++;
    if (valid_rr[2][0] !== 1'b1 || new_rr[2][0] !== 2'd0 || valid_lf[2][0] !== 1'b1 || new_lf[2][0] !== 2'd0) begin
      failed++;
      $display("FAIL idle_on_free: rr %b/%0d lf %b/%0d expected 1/0", valid_rr[2][0], new_rr[2][0], valid_lf[2][0], new_lf[2][0]);
    end
    tick();
    clear_inputs();
    do_reset();
    req[0][0] = 1'b1; cls[0][0] = 1'b1;
    repeat (2) begin
      #1 eval_model();
      tick();
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b1;
    idle[0][3] = 1'b1;
    #1 eval_model();
    tests++;
    if (valid_rr[0][1] !== 1'b1 || new_rr[0][1] !== 2'd0 || valid_lf[0][1] !== 1'b1 || new_lf[0][1] !== 2'd0) begin
      failed++;
      $display("FAIL same_edge_grant: rr %b/%0d lf %b/%0d expected 1/0", valid_rr[0][1], new_rr[0][1], valid_lf[0][1], new_lf[0][1]);
    end
    tick();
    idle = '0;
    req[0][1] = 1'b0;
    req[0][0] = 1'b1;
    #1 eval_model();
    tests++;
    if (valid_rr[0][0] !== 1'b1 || new_rr[0][0] !== 2'd3 || valid_lf[0][0] !== 1'b1 || new_lf[0][0] !== 2'd3) begin
      failed++;
      $display("FAIL same_edge_release: rr %b/%0d lf %b/%0d expected 1/3", valid_rr[0][0], new_rr[0][0], valid_lf[0][0], new_lf[0][0]);
    end
    tick();
    req[0][0] = 1'b0;
    req[0][1] = 1'b1;
    #1 eval_model();
    tests++;
    if (valid_rr[0][1] !== 1'b1 || new_rr[0][1] !== 2'd1 || valid_lf[0][1] !== 1'b1 || new_lf[0][1] !== 2'd1) begin
      failed++;
      $display("FAIL same_edge_occupied: rr %b/%0d lf %b/%0d expected 1/1", valid_rr[0][1], new_rr[0][1], valid_lf[0][1], new_lf[0][1]);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [P-1:0][V-1:0] granted = '0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < P; p++)
        for (int v = 0; v < V; v++) begin
          if (!(req[p][v] && !granted[p][v] && int'(port[p][v]) < P && $urandom_range(0, 7) != 0)) begin
            req[p][v] = ($urandom_range(0, 2) == 0);
            port[p][v] = port_t'($urandom_range(0, 6));
            cls[p][v] = class_t'($urandom_range(0, C - 1));
          end
          idle[p][v] = ($urandom_range(0, 5) == 0);
        end
      #1 eval_model();
      tests++;
      if ({valid_rr, new_rr, valid_lf, new_lf} !== {exp_valid[1], exp_new[1], exp_valid[0], exp_new[0]}) begin
        failed++;
        $display("FAIL random_cycle%0d: rr %h/%h lf %h/%h expected rr %h/%h lf %h/%h", i, valid_rr, new_rr, valid_lf, new_lf, exp_valid[1], exp_new[1], exp_valid[0], exp_new[0]);
      end
      granted = exp_valid[1];
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_model();
    test_reset();
    test_single();
    test_contention();
    test_input_rr();
    test_vc_select();
    test_boundaries();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
